// File: rtl/dp_mem_mmio.sv
// True-dual-port single-clock RAM with a window of memory-mapped output registers
// at the top of the address space and one synchronised input register.
module dp_mem_mmio #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 512,
    parameter int NUM_OUT = 2,
    parameter int OUT_W   = 8,
    parameter int IN_W    = 8,
    parameter int IN_ADDR = 509
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wea,
    input  logic [ADDR_W-1:0]        addra,
    input  logic [DATA_W-1:0]        dina,
    output logic [DATA_W-1:0]        douta,
    input  logic                     web,
    input  logic [ADDR_W-1:0]        addrb,
    input  logic [DATA_W-1:0]        dinb,
    output logic [DATA_W-1:0]        doutb,
    input  logic [IN_W-1:0]          io_in,
    output logic [NUM_OUT*OUT_W-1:0] io_out,
    output logic [NUM_OUT-1:0]       io_strobe
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] IN_ADDR_V = ADDR_W'(IN_ADDR);
    localparam logic [ADDR_W-1:0] WIN_BASE  = ADDR_W'(DEPTH - NUM_OUT);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IN_W-1:0]   io_meta;
    logic [IN_W-1:0]   io_sync;
    logic              in_range_a;
    logic              in_range_b;
    logic [NUM_OUT-1:0] hit_a;
    logic [NUM_OUT-1:0] hit_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    always_comb begin
        in_range_a = ({1'b0, addra} < DEPTH_V);
        in_range_b = ({1'b0, addrb} < DEPTH_V);
        for (int k = 0; k < NUM_OUT; k++) begin
            hit_a[k] = wea && (addra == WIN_BASE + ADDR_W'(k));
            hit_b[k] = web && (addrb == WIN_BASE + ADDR_W'(k));
        end
    end

    // The input register shadows memory for reads only; writes to it still land in RAM.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (addra == IN_ADDR_V)
            rd_a = DATA_W'(io_sync);
        else if (in_range_a)
            rd_a = mem[addra[IDX_W-1:0]];
        if (addrb == IN_ADDR_V)
            rd_b = DATA_W'(io_sync);
        else if (in_range_b)
            rd_b = mem[addrb[IDX_W-1:0]];
    end

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (web && in_range_b)
            mem[addrb[IDX_W-1:0]] <= dinb;
        if (wea && in_range_a)
            mem[addra[IDX_W-1:0]] <= dina;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta   <= '0;
            doutb   <= '0;
            io_meta <= '0;
            io_sync <= '0;
        end else begin
            douta   <= rd_a;
            doutb   <= rd_b;
            io_meta <= io_in;
            io_sync <= io_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_out    <= '0;
            io_strobe <= '0;
        end else begin
            io_strobe <= hit_a | hit_b;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (hit_a[k])
                    io_out[k*OUT_W +: OUT_W] <= dina[OUT_W-1:0];
                else if (hit_b[k])
                    io_out[k*OUT_W +: OUT_W] <= dinb[OUT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dp_mem_mmio.sv
// Self-checking bench for dp_mem_mmio: reset, directed vector table,
// randomized traffic against an array/queue reference model, and mid-operation reset.
module tb_dp_mem_mmio;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 512;
    localparam int NUM_OUT = 2;
    localparam int OUT_W   = 8;
    localparam int IN_W    = 8;
    localparam int IN_ADDR = 509;

    logic                     clk;
    logic                     rst_n;
    logic                     wea;
    logic [ADDR_W-1:0]        addra;
    logic [DATA_W-1:0]        dina;
    logic [DATA_W-1:0]        douta;
    logic                     web;
    logic [ADDR_W-1:0]        addrb;
    logic [DATA_W-1:0]        dinb;
    logic [DATA_W-1:0]        doutb;
    logic [IN_W-1:0]          io_in;
    logic [NUM_OUT*OUT_W-1:0] io_out;
    logic [NUM_OUT-1:0]       io_strobe;

    dp_mem_mmio #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_OUT(NUM_OUT),
        .OUT_W(OUT_W), .IN_W(IN_W), .IN_ADDR(IN_ADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wea(wea), .addra(addra), .dina(dina), .douta(douta),
        .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
        .io_in(io_in), .io_out(io_out), .io_strobe(io_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_failed   = 0;

    // Reference model: plain word array, per-word "written" flags, output bytes,
    // and the history of io_in values applied each cycle since reset.
    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];
    logic [7:0]  model_out [NUM_OUT];
    logic [7:0]  io_hist [$];

    logic [31:0] exp_a, exp_b;
    bit          exp_a_ok, exp_b_ok;
    logic [15:0] exp_io;
    logic [1:0]  exp_strobe;

    typedef struct {
        logic        wa;
        logic [9:0]  aa;
        logic [31:0] da;
        logic        wb;
        logic [9:0]  ab;
        logic [31:0] db;
        logic [7:0]  ii;
        bit          ca;
        logic [31:0] ea;
        bit          cb;
        logic [31:0] eb;
        logic [15:0] eio;
        logic [1:0]  es;
    } vec_t;

    vec_t vecs [17];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic predictRead(input logic [9:0] addr, output logic [31:0] val, output bit ok);
        int idx;
        idx = int'(addr);
        val = '0;
        ok  = 1'b1;
        if (idx >= DEPTH) begin
            val = '0;
        end else if (idx == IN_ADDR) begin
            if (io_hist.size() >= 2)
                val = {24'h0, io_hist[io_hist.size()-2]};
        end else begin
            ok  = model_known[idx];
            val = model_mem[idx];
        end
    endtask

    task automatic modelWrite(input logic [9:0] addr, input logic [31:0] d);
        int idx;
        idx = int'(addr);
        if (idx < DEPTH) begin
            model_mem[idx]   = d;
            model_known[idx] = 1'b1;
            if (idx >= DEPTH - NUM_OUT) begin
                model_out[idx-(DEPTH-NUM_OUT)]  = d[7:0];
                exp_strobe[idx-(DEPTH-NUM_OUT)] = 1'b1;
            end
        end
    endtask

    // Drives one cycle of inputs at the falling edge, advances the model,
    // and returns at the next falling edge with outputs ready to sample.
    task automatic applyStimulus(input logic wa, input logic [9:0] aa, input logic [31:0] da,
                                 input logic wb, input logic [9:0] ab, input logic [31:0] db,
                                 input logic [7:0] ii);
        wea = wa; addra = aa; dina = da;
        web = wb; addrb = ab; dinb = db;
        io_in = ii;
        predictRead(aa, exp_a, exp_a_ok);
        predictRead(ab, exp_b, exp_b_ok);
        exp_strobe = 2'b00;
        if (wb) modelWrite(ab, db);
        if (wa) modelWrite(aa, da);
        exp_io = {model_out[1], model_out[0]};
        io_hist.push_back(ii);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkModel(input string tag);
        if (exp_a_ok) checkOutput({tag, " douta"}, douta, exp_a);
        if (exp_b_ok) checkOutput({tag, " doutb"}, doutb, exp_b);
        checkOutput({tag, " io_out"}, {16'h0, io_out}, {16'h0, exp_io});
        checkOutput({tag, " io_strobe"}, {30'h0, io_strobe}, {30'h0, exp_strobe});
    endtask

    function automatic logic [9:0] randAddr();
        case ($urandom_range(0, 9))
            5: return 10'd509;
            6: return 10'd510;
            7: return 10'd511;
            8: return ($urandom_range(0, 1) == 0) ? 10'd600 : 10'd1023;
            9: return 10'($urandom_range(500, 511));
            default: return 10'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 10'd7,   32'h22,       1'b1, 10'd5,   32'hDEADBEEF, 8'h00, 1'b0, 32'h0,        1'b0, 32'h0,        16'h0000, 2'b00};
        vecs[1]  = '{1'b0, 10'd5,   32'h0,        1'b0, 10'd5,   32'h0,        8'h00, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 16'h0000, 2'b00};
        vecs[2]  = '{1'b1, 10'd7,   32'h11,       1'b0, 10'd7,   32'h0,        8'h00, 1'b1, 32'h22,       1'b1, 32'h22,       16'h0000, 2'b00};
        vecs[3]  = '{1'b0, 10'd7,   32'h0,        1'b0, 10'd7,   32'h0,        8'h00, 1'b1, 32'h11,       1'b1, 32'h11,       16'h0000, 2'b00};
        vecs[4]  = '{1'b1, 10'd511, 32'hA5,       1'b0, 10'd5,   32'h0,        8'h00, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 16'hA500, 2'b10};
        vecs[5]  = '{1'b0, 10'd511, 32'h0,        1'b0, 10'd5,   32'h0,        8'h00, 1'b1, 32'hA5,       1'b1, 32'hDEADBEEF, 16'hA500, 2'b00};
        vecs[6]  = '{1'b1, 10'd511, 32'hC3,       1'b1, 10'd510, 32'h3C,       8'h00, 1'b1, 32'hA5,       1'b0, 32'h0,        16'hC33C, 2'b11};
        vecs[7]  = '{1'b1, 10'd511, 32'h1,        1'b1, 10'd511, 32'h2,        8'h00, 1'b1, 32'hC3,       1'b1, 32'hC3,       16'h013C, 2'b10};
        vecs[8]  = '{1'b0, 10'd511, 32'h0,        1'b0, 10'd510, 32'h0,        8'h00, 1'b1, 32'h1,        1'b1, 32'h3C,       16'h013C, 2'b00};
        vecs[9]  = '{1'b0, 10'd509, 32'h0,        1'b0, 10'd5,   32'h0,        8'h5A, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF, 16'h013C, 2'b00};
        vecs[10] = '{1'b0, 10'd509, 32'h0,        1'b0, 10'd5,   32'h0,        8'h5A, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF, 16'h013C, 2'b00};
        vecs[11] = '{1'b0, 10'd509, 32'h0,        1'b0, 10'd5,   32'h0,        8'h5A, 1'b1, 32'h5A,       1'b1, 32'hDEADBEEF, 16'h013C, 2'b00};
        vecs[12] = '{1'b0, 10'd509, 32'h0,        1'b0, 10'd509, 32'h0,        8'h5A, 1'b1, 32'h5A,       1'b1, 32'h5A,       16'h013C, 2'b00};
        vecs[13] = '{1'b0, 10'd509, 32'h0,        1'b1, 10'd509, 32'hFFFF,     8'h5A, 1'b1, 32'h5A,       1'b1, 32'h5A,       16'h013C, 2'b00};
        vecs[14] = '{1'b0, 10'd509, 32'h0,        1'b0, 10'd1023, 32'h0,       8'h00, 1'b1, 32'h5A,       1'b1, 32'h0,        16'h013C, 2'b00};
        vecs[15] = '{1'b1, 10'd600, 32'h77,       1'b1, 10'd88,  32'h1234,     8'h00, 1'b1, 32'h0,        1'b0, 32'h0,        16'h013C, 2'b00};
        vecs[16] = '{1'b0, 10'd600, 32'h0,        1'b0, 10'd88,  32'h0,        8'h00, 1'b1, 32'h0,        1'b1, 32'h1234,     16'h013C, 2'b00};

        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) model_out[k] = 8'h00;

        rst_n = 1'b0;
        wea = 1'b0; addra = '0; dina = '0;
        web = 1'b0; addrb = '0; dinb = '0;
        io_in = 8'hFF;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("reset douta", douta, 32'h0);
            checkOutput("reset doutb", doutb, 32'h0);
            checkOutput("reset io_out", {16'h0, io_out}, 32'h0);
            checkOutput("reset io_strobe", {30'h0, io_strobe}, 32'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].wa, vecs[i].aa, vecs[i].da, vecs[i].wb, vecs[i].ab, vecs[i].db, vecs[i].ii);
            if (vecs[i].ca) checkOutput($sformatf("vec%0d douta", i), douta, vecs[i].ea);
            if (vecs[i].cb) checkOutput($sformatf("vec%0d doutb", i), doutb, vecs[i].eb);
            checkOutput($sformatf("vec%0d io_out", i), {16'h0, io_out}, {16'h0, vecs[i].eio});
            checkOutput($sformatf("vec%0d io_strobe", i), {30'h0, io_strobe}, {30'h0, vecs[i].es});
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom,
                          1'($urandom_range(0, 1)), randAddr(), $urandom,
                          8'($urandom));
            checkModel($sformatf("rand%0d", i));
        end

        // A write landing while reset is held must not reach the outputs.
        wea = 1'b1; addra = 10'd511; dina = 32'hEE;
        web = 1'b1; addrb = 10'd510; dinb = 32'h77;
        io_in = 8'hFF;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset io_out", {16'h0, io_out}, 32'h0);
        checkOutput("midreset io_strobe", {30'h0, io_strobe}, 32'h0);
        checkOutput("midreset douta", douta, 32'h0);
        checkOutput("midreset doutb", doutb, 32'h0);
        model_known[511] = 1'b0;
        model_known[510] = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) model_out[k] = 8'h00;
        io_hist.delete();
        wea = 1'b0; web = 1'b0;
        rst_n = 1'b1;

        model_mem[20] = 32'h0;
        applyStimulus(1'b1, 10'd20, 32'hCAFE0001, 1'b0, 10'd7, 32'h0, 8'hFF);
        checkModel("post0");
        for (int c = 1; c < 4; c++) begin
            applyStimulus(1'b0, 10'd509, 32'h0, 1'b0, 10'd20, 32'h0, 8'hFF);
            checkModel($sformatf("post%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/dp_mem_mmio.md
Name: dp_mem_mmio

Overview:
Parametrised true-dual-port, single-clock block RAM for the VSCPU: port A serves the CPU, port B serves the RS232 loader and debug path. A window of output registers sits at the top of the address space and drives board I/O such as LEDs, each with an update strobe. One input register returns a synchronised external input bus, such as switches. Read latency is one cycle on both ports.

Parameters:
DATA_W, 32, data width of both ports.
ADDR_W, 10, address width of both ports.
DEPTH, 512, number of memory words; must be <= 2**ADDR_W.
NUM_OUT, 2, number of output registers; 1..8.
OUT_W, 8, width of each output register; <= DATA_W.
IN_W, 8, width of the io_in bus; <= DATA_W.
IN_ADDR, 509, address that reads io_in; must lie below DEPTH-NUM_OUT.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous, active-low reset.
wea  in  1  port A write enable.
addra  in  ADDR_W  port A address.
dina  in  DATA_W  port A write data.
douta  out  DATA_W  port A read data, registered.
web  in  1  port B write enable.
addrb  in  ADDR_W  port B address.
dinb  in  DATA_W  port B write data.
doutb  out  DATA_W  port B read data, registered.
io_in  in  IN_W  asynchronous external input.
io_out  out  NUM_OUT*OUT_W  output registers; register k occupies bits [k*OUT_W +: OUT_W].
io_strobe  out  NUM_OUT  one-cycle pulse per output register on each update.

Behaviour:
- Reset (rst_n=0, async): douta=0, doutb=0, io_out=0, io_strobe=0, both io_in sync flops=0. Memory contents are not reset and persist across reset.
- Reads: dout* is updated every cycle, one cycle after the address is presented. The read is read-first: a read of an address written in the same cycle, by either port, returns the old content.
- Reads of IN_ADDR return io_sync zero-extended to DATA_W instead of memory.
  - io_sync is io_in passed through 2 flops, so a change on io_in is visible on a read issued 2 cycles later.
  - Writes to IN_ADDR go to memory only.
- Writes: memory[addr] <= din on the rising edge when we=1 and addr < DEPTH.
- Out-of-range addresses (addr >= DEPTH): writes are ignored; reads return 0.
- Output window: register k is at address DEPTH-NUM_OUT+k.
  - A write to that address updates memory and also sets io_out[k] <= din[OUT_W-1:0].
  - io_strobe[k] is 1 in the cycle after that edge, for exactly one cycle. Back-to-back writes give back-to-back strobes.
  - Reads of window addresses return memory contents, i.e. the full DATA_W word.
- Same-address write collision (wea and web both 1, addra == addrb): port A wins in memory and in io_out. io_strobe[k] still pulses once.
- Writes by both ports to different window registers in the same cycle: both registers update and both strobes pulse.
- Reset mid-operation: a write coincident with rst_n low is lost for io_out and io_strobe. The memory write outcome is unspecified in that case.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with io_in=8'hFF -> douta=0, doutb=0, io_out=16'h0000, io_strobe=2'b00 throughout.
- Cross-port write/read: port B writes 32'hDEADBEEF to addr 5; port A reads addr 5 on the next cycle -> douta=32'hDEADBEEF one cycle later.
- Read-first: A writes 32'h11 to addr 7, which holds 32'h22, while B reads addr 7 in the same cycle -> doutb=32'h22; B reads addr 7 again -> doutb=32'h11.
- Output window:
  - A writes 32'h000000A5 to 511 -> io_out[15:8]=8'hA5, io_strobe=2'b10 for exactly 1 cycle.
  - B writes 32'h3C to 510 in the same cycle -> io_out[7:0]=8'h3C, io_strobe=2'b11.
- Collision: A writes 32'h1 and B writes 32'h2 to 511 in the same cycle -> io_out[15:8]=8'h01; a later read of 511 returns 32'h1; io_strobe[1] pulses once.
- Input and out-of-range:
  - io_in=8'h5A, then A reads 509 three cycles later -> douta=32'h0000005A.
  - Write to 600, then read 600 -> douta=0; memory is unchanged.
